// File: rtl/f_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction-memory port,
// and the F/D pipeline latch out to the D stage.
interface f_fetch_stage_if;
  logic        stall;
  logic        npc_sel;
  logic [31:0] npc;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] F_PC;
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic        D_valid;
  logic        D_exc_adel;
  logic [31:0] fetch_count;

  // master: the fetch stage itself; slave: the surrounding pipeline and memory
  modport master (
    input  stall, npc_sel, npc, im_rdata,
    output im_addr, F_PC, D_pc, D_instr, D_valid, D_exc_adel, fetch_count
  );

  modport slave (
    output stall, npc_sel, npc, im_rdata,
    input  im_addr, F_PC, D_pc, D_instr, D_valid, D_exc_adel, fetch_count
  );
endinterface

// File: rtl/f_fetch_stage.sv
// MIPS instruction-fetch stage: F-stage PC, instruction-memory address,
// fetch-address checking and the F/D pipeline latch with a fetch counter.
module f_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input logic              clk,
  input logic              reset,
  f_fetch_stage_if.master  bus
);

  // Upper bound is one bit wider so a range ending at 2^32 cannot wrap.
  localparam logic [32:0] LP_PC_HI = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);

  logic [31:0] r_f_pc;
  logic [31:0] r_d_pc;
  logic [31:0] r_d_instr;
  logic        r_d_valid;
  logic        r_d_exc_adel;
  logic [31:0] r_fetch_count;

  logic [31:0] w_nextpc;
  logic        w_adel;

  // Redirect comes from D; the instruction fetched this cycle is the delay slot.
  assign w_nextpc = bus.npc_sel ? bus.npc : (r_f_pc + 32'd4);

  assign w_adel = (r_f_pc[1:0] != 2'b00)
               || (r_f_pc < PC_RESET)
               || ({1'b0, r_f_pc} >= LP_PC_HI);

  // NOTE: reset is synchronous and checked first so it overrides stall and redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_pc        <= PC_RESET;
      r_d_pc        <= PC_RESET;
      r_d_instr     <= 32'h0000_0000;
      r_d_valid     <= 1'b0;
      r_d_exc_adel  <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (!bus.stall) begin
      r_f_pc        <= w_nextpc;
      r_d_pc        <= r_f_pc;
      r_d_instr     <= w_adel ? 32'h0000_0000 : bus.im_rdata;
      r_d_valid     <= 1'b1;
      r_d_exc_adel  <= w_adel;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign bus.im_addr     = r_f_pc;
  assign bus.F_PC        = r_f_pc;
  assign bus.D_pc        = r_d_pc;
  assign bus.D_instr     = r_d_instr;
  assign bus.D_valid     = r_d_valid;
  assign bus.D_exc_adel  = r_d_exc_adel;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Self-checking bench for f_fetch_stage: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_f_fetch_stage;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 4096;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        adel;
  } d_slot_t;

  logic clk = 1'b0;
  logic reset;
  f_fetch_stage_if bus ();

  f_fetch_stage #(.PC_RESET(PC_RESET), .IM_WORDS(IM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  always_comb bus.im_rdata = mem_word(bus.im_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: legal window as plain 64-bit integers, PC arithmetic mod 2^32.
  logic [31:0] m_fpc;
  d_slot_t     m_d;
  logic [31:0] m_cnt;
  bit          m_live = 1'b0;

  function automatic bit is_bad(input logic [31:0] pc);
    longint unsigned p, lo, hi;
    p  = longint'(pc);
    lo = longint'(PC_RESET);
    hi = lo + 4 * longint'(IM_WORDS);
    return (p % 4 != 0) || (p < lo) || (p >= hi);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_fpc  = PC_RESET;
      m_d    = '{pc: PC_RESET, instr: 32'h0, valid: 1'b0, adel: 1'b0};
      m_cnt  = 32'd0;
      m_live = 1'b1;
    end else if (m_live && !bus.stall) begin
      m_d.pc    = m_fpc;
      m_d.adel  = is_bad(m_fpc);
      m_d.instr = m_d.adel ? 32'h0 : mem_word(m_fpc);
      m_d.valid = 1'b1;
      m_cnt     = 32'((longint'(m_cnt) + 1) % (longint'(1) << 32));
      m_fpc     = bus.npc_sel ? bus.npc : 32'((longint'(m_fpc) + 4) % (longint'(1) << 32));
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("F_PC",        bus.F_PC,        m_fpc);
      check("im_addr",     bus.im_addr,     m_fpc);
      check("D_pc",        bus.D_pc,        m_d.pc);
      check("D_instr",     bus.D_instr,     m_d.instr);
      check("D_valid",     32'(bus.D_valid),    32'(m_d.valid));
      check("D_exc_adel",  32'(bus.D_exc_adel), 32'(m_d.adel));
      check("fetch_count", bus.fetch_count, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic st, input logic sel, input logic [31:0] target);
    reset       = rst;
    bus.stall   = st;
    bus.npc_sel = sel;
    bus.npc     = target;
  endtask

  // Redirect to target, let it enter D, then check the fault flag and instruction.
  task automatic fetch_at(input logic [31:0] target, input logic exp_adel, input string tag);
    drive(1'b0, 1'b0, 1'b1, target);
    step();
    check({tag, "_fpc"}, bus.F_PC, target);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check({tag, "_dpc"},   bus.D_pc, target);
    check({tag, "_adel"},  32'(bus.D_exc_adel), 32'(exp_adel));
    check({tag, "_instr"}, bus.D_instr, exp_adel ? 32'h0 : (target ^ 32'hA5A5_0000));
  endtask

  initial begin
    logic [31:0] cnt_snap;
    logic [31:0] tgt;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    step();
    check("rst_fpc",   bus.F_PC, 32'h0000_3000);
    check("rst_dpc",   bus.D_pc, 32'h0000_3000);
    check("rst_instr", bus.D_instr, 32'h0);
    check("rst_valid", 32'(bus.D_valid), 32'd0);
    check("rst_cnt",   bus.fetch_count, 32'd0);

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("seq1_fpc",   bus.F_PC, 32'h0000_3004);
    check("seq1_dpc",   bus.D_pc, 32'h0000_3000);
    check("seq1_instr", bus.D_instr, 32'hA5A5_3000);
    check("seq1_valid", 32'(bus.D_valid), 32'd1);
    check("seq1_cnt",   bus.fetch_count, 32'd1);
    step();
    check("seq2_fpc", bus.F_PC, 32'h0000_3008);
    check("seq2_cnt", bus.fetch_count, 32'd2);
    step();
    check("seq3_cnt", bus.fetch_count, 32'd3);
    step();
    check("pre_redir_fpc", bus.F_PC, 32'h0000_3010);
    check("pre_redir_dpc", bus.D_pc, 32'h0000_300C);

    // Delay slot: 3010 still enters D, then the target.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_3100);
    step();
    check("redir_fpc", bus.F_PC, 32'h0000_3100);
    check("slot_dpc",  bus.D_pc, 32'h0000_3010);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("tgt_dpc",  bus.D_pc, 32'h0000_3100);
    check("tgt_fpc",  bus.F_PC, 32'h0000_3104);

    // Stall wins over a simultaneous redirect; the redirect lands exactly once.
    cnt_snap = bus.fetch_count;
    drive(1'b0, 1'b1, 1'b1, 32'h0000_3200);
    step();
    step();
    check("stall_fpc",   bus.F_PC, 32'h0000_3104);
    check("stall_dpc",   bus.D_pc, 32'h0000_3100);
    check("stall_cnt",   bus.fetch_count, cnt_snap);
    check("stall_addr",  bus.im_addr, 32'h0000_3104);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_3200);
    step();
    check("release_fpc", bus.F_PC, 32'h0000_3200);
    check("release_cnt", bus.fetch_count, cnt_snap + 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("once_fpc", bus.F_PC, 32'h0000_3204);

    fetch_at(32'h0000_3002, 1'b1, "misalign");
    fetch_at(32'h0000_7000, 1'b1, "above");
    fetch_at(32'h0000_2FFC, 1'b1, "below");
    fetch_at(32'h0000_6FFC, 1'b0, "top_word");

    // Reset during stall+redirect discards the redirect.
    drive(1'b1, 1'b1, 1'b1, 32'h0000_3400);
    step();
    check("rr_fpc",   bus.F_PC, 32'h0000_3000);
    check("rr_valid", 32'(bus.D_valid), 32'd0);
    check("rr_instr", bus.D_instr, 32'h0);
    check("rr_cnt",   bus.fetch_count, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("rr_next_dpc", bus.D_pc, 32'h0000_3000);
    check("rr_next_fpc", bus.F_PC, 32'h0000_3004);

    // PC wrap at the top of the address space.
    cnt_snap = bus.fetch_count;
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("wrap_dpc",  bus.D_pc, 32'hFFFF_FFFC);
    check("wrap_adel", 32'(bus.D_exc_adel), 32'd1);
    check("wrap_fpc",  bus.F_PC, 32'h0);
    step();
    check("zero_dpc",  bus.D_pc, 32'h0);
    check("zero_adel", 32'(bus.D_exc_adel), 32'd1);
    check("wrap_cnt",  bus.fetch_count, cnt_snap + 32'd3);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: tgt = PC_RESET + 32'(4 * $urandom_range(0, IM_WORDS - 1));
        6:                tgt = $urandom;
        7:                tgt = PC_RESET + 32'(4 * $urandom_range(0, 100)) + 32'($urandom_range(1, 3));
        8:                tgt = PC_RESET - 32'd4;
        default:          tgt = PC_RESET + 32'(4 * IM_WORDS);
      endcase
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 99) < 15), tgt);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/f_fetch_stage.md
Name: f_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the F-stage program counter, drives the instruction-memory address, and registers the F/D pipeline latch consumed by the D stage.
- Each cycle the next PC is either sequential (F_PC+4) or the redirect target produced by the D-stage next-PC logic (branch/j/jal/jr/jalr).
- The architectural delay slot is honoured: no F/D flush on redirect.
- Also performs fetch-address checking (alignment and range) and keeps a retired-fetch counter.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_WORDS, 4096, instruction memory depth in 32-bit words; legal fetch range is [PC_RESET, PC_RESET + 4*IM_WORDS).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  from hazard unit; freezes F_PC and the F/D latch.
- npc_sel  input  1  D stage requests redirect (taken branch or any jump).
- npc  input  32  redirect target from the D-stage next-PC logic.
- im_addr  output  32  word address to instruction memory, equals F_PC (combinational).
- im_rdata  input  32  instruction word returned combinationally for im_addr.
- F_PC  output  32  current fetch PC (registered).
- D_pc  output  32  PC of the instruction in D.
- D_instr  output  32  instruction in D.
- D_valid  output  1  D holds a real fetched instruction (not reset bubble).
- D_exc_adel  output  1  fetch address error for the D instruction.
- fetch_count  output  32  number of instructions accepted into D since reset.

Behaviour:
- All registers update only on the rising edge of clk. reset dominates every other input.
- Reset values:
  - F_PC = PC_RESET.
  - D_pc = PC_RESET.
  - D_instr = 32'h0000_0000 (sll $0,$0,0, i.e. nop).
  - D_valid = 0, D_exc_adel = 0, fetch_count = 0.
- Next-PC selection:
  - nextpc = npc if npc_sel else F_PC + 32'd4.
  - Addition is modulo 2^32; F_PC = 32'hFFFF_FFFC wraps to 0, which is then flagged out of range.
- PC update:
  - If !stall: F_PC <= nextpc.
  - If stall: F_PC holds.
  - stall and npc_sel both high: stall wins and the redirect is not latched. The D instruction is held, so npc_sel is re-presented next cycle; no redirect may be lost or applied twice.
- Fetch check (combinational on F_PC):
  - adel = (F_PC[1:0] != 0) OR (F_PC < PC_RESET) OR (F_PC >= PC_RESET + 4*IM_WORDS).
  - Comparisons are unsigned 32-bit; the upper bound is computed in 33 bits to avoid overflow.
- F/D latch:
  - If !stall:
    - D_pc <= F_PC.
    - D_instr <= adel ? 32'h0 : im_rdata.
    - D_exc_adel <= adel.
    - D_valid <= 1.
  - If stall: all D_* outputs hold.
- Delay slot: on redirect, the instruction fetched in the same cycle (F_PC = D_pc+4) enters D normally. The redirect affects only the following fetch.
- fetch_count:
  - Increments by 1 on every non-stalled, non-reset edge, including faulted fetches.
  - Wraps 32'hFFFF_FFFF -> 0.
- Reset asserted mid-stall or mid-redirect: next edge gives exactly the reset values; pending npc_sel is discarded.
- im_addr = F_PC at all times, including during stall.
- No combinational path from npc/npc_sel to any output.

Test Plan:
- Reset held 2 cycles, then released with stall=0, npc_sel=0, im_rdata = F_PC ^ 32'hA5A5_0000:
  - F_PC steps 3000, 3004, 3008.
  - D_pc lags one cycle, D_instr = 32'hA5A5_3000 after the first edge, D_valid rises after the first post-reset edge.
  - fetch_count counts 1, 2, 3.
- Redirect with delay slot: at F_PC=3010 (D_pc=300C), pulse npc_sel=1, npc=32'h0000_3100 for one cycle:
  - Next F_PC=3100.
  - D receives 3010 (delay slot), then 3100.
- Stall with simultaneous redirect: stall=1 and npc_sel=1, npc=3200 for 2 cycles, then stall=0 with npc_sel=1 held:
  - F_PC and D_* frozen for both stalled cycles.
  - After release, F_PC=3200 exactly once and fetch_count is unchanged during the stall.
- Address error: npc=32'h0000_3002:
  - D_exc_adel=1 and D_instr=0 for D_pc=3002.
  - Repeat with npc=32'h0000_7000 (first out-of-range word for IM_WORDS=4096) and npc=32'h0000_2FFC; both give D_exc_adel=1.
  - npc=32'h0000_6FFC gives D_exc_adel=0.
- Reset during stall plus redirect: stall=1, npc_sel=1, npc=3400, reset=1 for one edge:
  - F_PC=3000, D_valid=0, D_instr=0, fetch_count=0.
  - Next fetch is 3000, not 3400.
- Wrap: jr to 32'hFFFF_FFFC:
  - D_exc_adel=1.
  - Next F_PC=0, also flagged.
  - fetch_count still increments.
